uart_loader_ram: RTL and testbench
==================================

# uart_loader_ram

Parametrised UART program loader and instruction memory for the Mini-CPU; the successor of the fixed 16-bit/256-word loader. In load mode it receives LSB-first 8N1 bytes on `rx`, assembles them little-endian into `WORD_BYTES`-byte words and writes them sequentially into a `2**ADDR_W`-deep RAM. In run mode it serves instruction fetches at `addr_pc` and passes received bytes to the CPU bus as user input, with a valid/overrun handshake. It adds stop-bit framing checks, false-start rejection and a load-word counter.

## Interface
- `CLKS_PER_BIT`, 234, clocks per UART bit; must be at least 4.
- `WORD_BYTES`, 2, bytes per RAM word; 1–4. `DATA_W = 8*WORD_BYTES`.
- `ADDR_W`, 8, RAM address width; depth is `2**ADDR_W`.
- `clk` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx` in 1: UART serial input; idles high.
- `button` in 1: mode toggle; acts on its falling edge.
- `addr_pc` in ADDR_W: fetch address.
- `read_en` in 1: CPU reads the user byte.
- `data_out` out DATA_W: fetched word.
- `mode` out 1: 0 = load, 1 = run.
- `bus` out 8: `data_reg` when `read_en`=1, else high-Z.
- `byte_ready` out 1: one-cycle pulse per good byte.
- `frame_err` out 1: one-cycle pulse per bad frame.
- `user_valid` out 1: unread user byte held.
- `overrun` out 1: sticky flag.
- `load_count` out ADDR_W+1: words written since load mode was entered.

## Operation
- `rx` and `button` each pass through 2-FF synchronisers, reset to 1. All logic uses the synchronised versions.
- FSM states: IDLE, START, DATA, PARITY (macro builds only), STOP.
  - IDLE→START on a synchronised `rx` 1→0 edge.
  - START: at `CLKS_PER_BIT/2` (integer division), sample `rx`. If 0, go to DATA with the counter cleared. If 1, it is a false start: return to IDLE with no pulse.
  - DATA: sample every `CLKS_PER_BIT` clocks. After 8 samples go to PARITY or STOP. The shift register fills LSB-first.
  - STOP: sample after `CLKS_PER_BIT` clocks, then go to IDLE.
    - Stop=1 and parity OK: the byte is good. Pulse `byte_ready`.
    - Otherwise: pulse `frame_err`, discard the byte, and reset the byte index to 0 so a partial word is dropped.
- Load mode (`mode`=0), on each good byte:
  - Store it at byte lane `idx`; `idx` increments.
  - When `idx` reaches `WORD_BYTES-1`, the next cycle writes `mem[wr_ptr]`, increments `wr_ptr` and clears `idx`.
  - `wr_ptr` wraps from `2**ADDR_W-1` to 0.
  - `load_count` increments and saturates at `2**ADDR_W`.
- Mode toggles on a synchronised `button` 1→0 edge.
  - Entering load mode clears `wr_ptr`, `idx` and `load_count`.
  - Entering run mode clears `idx`.
- Run mode (`mode`=1):
  - `data_out` <= `mem[addr_pc]` every cycle. In load mode `data_out` <= 0.
  - A good byte loads `data_reg` and sets `user_valid`.
  - If `user_valid` is already 1 and `read_en` is 0 on that cycle, `overrun` sets and the new byte still overwrites `data_reg`.
  - `read_en`=1 clears `user_valid` on the next edge. If a byte arrives on the same cycle, the set wins.
  - `overrun` clears only on entering load mode.
  - RAM is never written in run mode.
- A mode toggle mid-frame does not disturb the FSM. The byte is routed by `mode` at the moment the byte completes.

## Timing
- Reset values:
  - `mode`=0, `data_out`=0, `byte_ready`=0, `frame_err`=0, `user_valid`=0, `overrun`=0, `load_count`=0.
  - `data_reg`=0, FSM=IDLE, counters 0.
  - `bus` is high-Z unless `read_en`=1.
  - RAM contents are not reset.
- Reset mid-frame aborts the frame immediately. No pulse is produced.
- `byte_ready`/`frame_err` assert the cycle after the stop sample.
- RAM write happens one cycle after `byte_ready`.
- Fetch latency: 1 cycle from `addr_pc` to `data_out`.
- Sample points relative to the synchronised falling edge:
  - Start: `CLKS_PER_BIT/2`.
  - Data bit k: `CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT`.
- Two stop-to-start back-to-back frames must be received. After the stop sample, IDLE immediately accepts a new edge.

## Configuration
- `UART_LOADER_PARITY_EN` defined: frames are 8E1. The PARITY state samples one bit `CLKS_PER_BIT` after bit 7. Odd overall parity on data+parity yields `frame_err`, and the byte is discarded as for a bad stop bit.
- Not defined: frames are 8N1 and no PARITY state exists.

## Test plan
All scenarios use `CLKS_PER_BIT`=16, `WORD_BYTES`=2, `ADDR_W`=4.
- Load: send 0x34,0x12,0x78,0x56, toggle to run, fetch addr 0/1 -> `data_out`=0x1234/0x5678 one cycle after `addr_pc`; `load_count`=2.
- Framing: send 0x34, then 0xAA with stop=0, then 0x11,0x22 -> one `frame_err` pulse; mem[0]=0x2211 (partial word dropped).
- Glitch: `rx` low for 4 clocks -> no pulse, FSM back in IDLE.
- Wrap: load 17 words -> word 17 overwrites mem[0]; `load_count`=16 (saturated).
- Run-mode handshake:
  - Send 0x41 -> `user_valid`=1, `bus`=0x41 with `read_en`.
  - Read it, send 0x42 and 0x43 without reading -> `overrun`=1, `data_reg`=0x43.
- Reset: assert `reset_n`=0 mid-byte -> all outputs at reset values, `mode`=0. Next full frame is received correctly.

Source files
------------

// File: rtl/uart_loader_ram_if.sv
// rtl/uart_loader_ram_if.sv - host/CPU-side signal bundle for uart_loader_ram
interface uart_loader_ram_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              rx;
  logic              button;
  logic [ADDR_W-1:0] addr_pc;
  logic              read_en;
  logic [DATA_W-1:0] data_out;
  logic              mode;
  logic              byte_ready;
  logic              frame_err;
  logic              user_valid;
  logic              overrun;
  logic [ADDR_W:0]   load_count;

  modport master (
    output rx, button, addr_pc, read_en,
    input  data_out, mode, byte_ready, frame_err, user_valid, overrun, load_count
  );

  modport slave (
    input  rx, button, addr_pc, read_en,
    output data_out, mode, byte_ready, frame_err, user_valid, overrun, load_count
  );
endinterface

// File: rtl/uart_loader_ram.sv
// rtl/uart_loader_ram.sv - UART program loader and instruction RAM for the Mini-CPU
// Optional 8E1 framing is enabled by defining UART_LOADER_PARITY_EN.
module uart_loader_ram #(
  parameter int CLKS_PER_BIT = 234,
  parameter int WORD_BYTES   = 2,
  parameter int ADDR_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_loader_ram_if.slave ifc,
  output wire [7:0]        bus
);
  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_W-1:0]  HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_LANE = IDX_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_LOADER_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  logic rx_m_q, rx_s_q, rx_p_q;
  logic btn_m_q, btn_s_q, btn_p_q;
  logic rx_fall, btn_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_p_q  <= 1'b1;
      btn_m_q <= 1'b1;
      btn_s_q <= 1'b1;
      btn_p_q <= 1'b1;
    end else begin
      rx_m_q  <= ifc.rx;
      rx_s_q  <= rx_m_q;
      rx_p_q  <= rx_s_q;
      btn_m_q <= ifc.button;
      btn_s_q <= btn_m_q;
      btn_p_q <= btn_s_q;
    end
  end

  assign rx_fall  = rx_p_q & ~rx_s_q;
  assign btn_fall = btn_p_q & ~btn_s_q;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             byte_ready_q;
  logic             frame_err_q;
  logic             byte_mode_q;
  logic             mode_q;
  logic             par_ok;

`ifdef UART_LOADER_PARITY_EN
  logic par_q;
  assign par_ok = ~^{shift_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  // Receiver; byte_mode_q latches the mode at the stop sample so the byte is routed by it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
      byte_mode_q  <= 1'b0;
`ifdef UART_LOADER_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      byte_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (rx_fall) state_q <= S_START;
        end
        S_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) begin
`ifdef UART_LOADER_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_LOADER_PARITY_EN
        S_PARITY: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            par_q   <= rx_s_q;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            if (rx_s_q && par_ok) begin
              byte_ready_q <= 1'b1;
              byte_mode_q  <= mode_q;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [IDX_W-1:0]  idx_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   load_count_q;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] word_d;
  logic [DATA_W-1:0] data_out_q;
  logic [7:0]        data_reg_q;
  logic              user_valid_q;
  logic              overrun_q;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_comb begin
    word_d = word_q;
    word_d[idx_q*8 +: 8] = shift_q;
  end

  assign mem_we = byte_ready_q & ~byte_mode_q & (idx_q == LAST_LANE);

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= word_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q       <= 1'b0;
      idx_q        <= '0;
      wr_ptr_q     <= '0;
      load_count_q <= '0;
      word_q       <= '0;
      data_out_q   <= '0;
      data_reg_q   <= '0;
      user_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      data_out_q <= mode_q ? mem_q[ifc.addr_pc] : '0;

      if (byte_ready_q && !byte_mode_q) begin
        word_q <= word_d;
        if (idx_q == LAST_LANE) begin
          idx_q    <= '0;
          wr_ptr_q <= wr_ptr_q + 1'b1;
          if (load_count_q != COUNT_MAX) load_count_q <= load_count_q + 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end

      // A bad frame drops any partially assembled word.
      if (frame_err_q) idx_q <= '0;

      if (ifc.read_en) user_valid_q <= 1'b0;
      if (byte_ready_q && byte_mode_q) begin
        data_reg_q   <= shift_q;
        user_valid_q <= 1'b1;
        if (user_valid_q && !ifc.read_en) overrun_q <= 1'b1;
      end

      if (btn_fall) begin
        mode_q <= ~mode_q;
        idx_q  <= '0;
        if (mode_q) begin
          wr_ptr_q     <= '0;
          load_count_q <= '0;
          overrun_q    <= 1'b0;
        end
      end
    end
  end

  assign ifc.data_out   = data_out_q;
  assign ifc.mode       = mode_q;
  assign ifc.byte_ready = byte_ready_q;
  assign ifc.frame_err  = frame_err_q;
  assign ifc.user_valid = user_valid_q;
  assign ifc.overrun    = overrun_q;
  assign ifc.load_count = load_count_q;
  assign bus            = ifc.read_en ? data_reg_q : 8'bz;
endmodule

// File: tb/tb_uart_loader_ram.sv
// tb/tb_uart_loader_ram.sv - self-checking bench for uart_loader_ram
module tb_uart_loader_ram;
  localparam int CPB   = 16;
  localparam int WB    = 2;
  localparam int AW    = 4;
  localparam int DW    = 8 * WB;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  wire [7:0] bus;

  uart_loader_ram_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

  uart_loader_ram #(.CLKS_PER_BIT(CPB), .WORD_BYTES(WB), .ADDR_W(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ifc     (ifc.slave),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int br_cnt = 0;
  int fe_cnt = 0;

  always @(negedge clk) begin
    if (ifc.byte_ready) br_cnt++;
    if (ifc.frame_err) fe_cnt++;
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] prev;
    logic [DW-1:0] exp;
  } fetch_vec_t;

  fetch_vec_t    fvec [3];
  logic [DW-1:0] mdl_mem [DEPTH];
  int            mdl_cnt;
  logic          m_valid, m_ovr;
  logic [7:0]    m_data, rb, b;
  logic [DW-1:0] word;
  int            br0, fe0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    ifc.rx = 1'b0;
    tick(CPB);
    for (int k = 0; k < 8; k++) begin
      ifc.rx = d[k];
      tick(CPB);
    end
    ifc.rx = stop;
    tick(CPB);
    ifc.rx = 1'b1;
    tick(4);
  endtask

  task automatic toggle();
    ifc.button = 1'b0;
    tick(4);
    ifc.button = 1'b1;
    tick(4);
  endtask

  task automatic fetch_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    ifc.addr_pc = a;
    @(posedge clk);
    @(negedge clk);
    check(name, ifc.data_out, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic read_user(output logic [7:0] d);
    ifc.read_en = 1'b1;
    @(negedge clk);
    d = bus;
    @(posedge clk);
    #1;
    ifc.read_en = 1'b0;
  endtask

  initial begin
    ifc.rx = 1'b1;
    ifc.button = 1'b1;
    ifc.read_en = 1'b0;
    ifc.addr_pc = '0;
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(3);

    check("rst_mode", ifc.mode, 0);
    check("rst_data_out", ifc.data_out, 0);
    check("rst_byte_ready", ifc.byte_ready, 0);
    check("rst_frame_err", ifc.frame_err, 0);
    check("rst_user_valid", ifc.user_valid, 0);
    check("rst_overrun", ifc.overrun, 0);
    check("rst_load_count", ifc.load_count, 0);

    // Basic load and fetch with one-cycle latency
    send_frame(8'h34, 1'b1);
    send_frame(8'h12, 1'b1);
    send_frame(8'h78, 1'b1);
    send_frame(8'h56, 1'b1);
    check("load_count_2", ifc.load_count, 2);
    check("load_data_out_zero", ifc.data_out, 0);
    toggle();
    check("mode_run", ifc.mode, 1);
    fvec[0] = '{addr: 4'd0, prev: 16'h1234, exp: 16'h1234};
    fvec[1] = '{addr: 4'd1, prev: 16'h1234, exp: 16'h5678};
    fvec[2] = '{addr: 4'd0, prev: 16'h5678, exp: 16'h1234};
    for (int i = 0; i < 3; i++) begin
      ifc.addr_pc = fvec[i].addr;
      @(negedge clk);
      check($sformatf("fetch_hold_%0d", i), ifc.data_out, fvec[i].prev);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("fetch_%0d", i), ifc.data_out, fvec[i].exp);
      @(posedge clk);
      #1;
    end

    // Framing error drops the partial word
    toggle();
    check("mode_load", ifc.mode, 0);
    check("load_count_cleared", ifc.load_count, 0);
    br0 = br_cnt;
    fe0 = fe_cnt;
    send_frame(8'h34, 1'b1);
    send_frame(8'hAA, 1'b0);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("frame_err_pulses", fe_cnt - fe0, 1);
    check("frame_good_pulses", br_cnt - br0, 3);
    check("frame_load_count", ifc.load_count, 1);
    toggle();
    fetch_check("frame_mem0", 4'd0, 16'h2211);

    // Glitch on rx, then run-mode handshake
    br0 = br_cnt;
    fe0 = fe_cnt;
    ifc.rx = 1'b0;
    tick(4);
    ifc.rx = 1'b1;
    tick(3 * CPB);
    check("glitch_no_good", br_cnt - br0, 0);
    check("glitch_no_err", fe_cnt - fe0, 0);
    send_frame(8'h41, 1'b1);
    check("hs_pulse_after_glitch", br_cnt - br0, 1);
    check("hs_valid", ifc.user_valid, 1);
    check("hs_overrun0", ifc.overrun, 0);
    read_user(rb);
    check("hs_bus_41", rb, 8'h41);
    check("hs_valid_cleared", ifc.user_valid, 0);
    send_frame(8'h42, 1'b1);
    send_frame(8'h43, 1'b1);
    check("hs_overrun", ifc.overrun, 1);
    check("hs_valid2", ifc.user_valid, 1);
    read_user(rb);
    check("hs_bus_43", rb, 8'h43);

    // Wrap: 17 random words, count saturates
    toggle();
    check("wrap_overrun_cleared", ifc.overrun, 0);
    mdl_cnt = 0;
    for (int w = 0; w < DEPTH + 1; w++) begin
      word = DW'($urandom);
      mdl_mem[w % DEPTH] = word;
      mdl_cnt = (w + 1 > DEPTH) ? DEPTH : w + 1;
      send_frame(word[7:0], 1'b1);
      send_frame(word[15:8], 1'b1);
    end
    check("wrap_load_count", ifc.load_count, mdl_cnt);
    toggle();
    for (int a = 0; a < DEPTH; a++) fetch_check($sformatf("wrap_mem%0d", a), AW'(a), mdl_mem[a]);

    // Random run-mode byte stream with random reads
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_data = 8'h43;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        read_user(rb);
        check($sformatf("rand_read_%0d", i), rb, m_data);
        m_valid = 1'b0;
      end
      b = 8'($urandom);
      send_frame(b, 1'b1);
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data = b;
      check($sformatf("rand_valid_%0d", i), ifc.user_valid, m_valid);
      check($sformatf("rand_ovr_%0d", i), ifc.overrun, m_ovr);
    end
    read_user(rb);
    check("rand_final_read", rb, m_data);

    // Reset in the middle of a frame
    br0 = br_cnt;
    fe0 = fe_cnt;
    ifc.rx = 1'b0;
    tick(CPB);
    ifc.rx = 1'b1;
    tick(CPB);
    ifc.rx = 1'b0;
    tick(CPB / 2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_mode", ifc.mode, 0);
    check("mid_rst_data_out", ifc.data_out, 0);
    check("mid_rst_user_valid", ifc.user_valid, 0);
    check("mid_rst_overrun", ifc.overrun, 0);
    check("mid_rst_load_count", ifc.load_count, 0);
    ifc.rx = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(12 * CPB);
    check("mid_rst_no_good", br_cnt - br0, 0);
    check("mid_rst_no_err", fe_cnt - fe0, 0);
    send_frame(8'h5A, 1'b1);
    send_frame(8'hA5, 1'b1);
    check("post_rst_load_count", ifc.load_count, 1);
    toggle();
    fetch_check("post_rst_mem0", 4'd0, 16'hA55A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
